// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: address width, instruction size and the
// program-counter sequencer state type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the program counter and drives instruction fetch.
// A resolved branch/jump redirects the PC and holds a flush for FLUSH_CYCLES
// cycles before fetch resumes at the target. A misaligned redirect target
// parks the unit in HALT with a sticky error until reset.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch counters
// (stat_branches, stat_taken); without it those ports do not exist.
module pc_redirect_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter int unsigned      FLUSH_CYCLES = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_pc,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic             br_jump,
    input  logic [XLEN-1:0]  br_target,
    output logic             flush,
    output logic             misalign_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_taken
`endif
);

    localparam int unsigned     CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(INSN_BYTES);

    pc_state_t          state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               flush_q, flush_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic redirect;
    logic target_aligned;

    assign redirect       = br_valid & (br_taken | br_jump);
    assign target_aligned = (br_target[1:0] == 2'b00);

    assign fetch_valid  = valid_q;
    assign fetch_pc     = pc_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;

    // State and output registers; everything the unit presents is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: misaligned redirect beats a normal redirect, which
    // beats stall, which beats the fetch handshake.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        flush_d    = flush_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        if (state_q != HALT && redirect && !target_aligned) begin
            // PC deliberately left at its current value for post-mortem.
            state_d    = HALT;
            misalign_d = 1'b1;
            valid_d    = 1'b0;
            flush_d    = 1'b1;
        end else begin
            case (state_q)
                BOOT, RUN: begin
                    if (redirect) begin
                        state_d = FLUSH;
                        pc_d    = br_target;
                        valid_d = 1'b0;
                        flush_d = 1'b1;
                        cnt_d   = CNT_RELOAD;
                    end else if (state_q == BOOT) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else if (valid_q && fetch_ready && !stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        // A younger redirect restarts the flush window.
                        pc_d  = br_target;
                        cnt_d = CNT_RELOAD;
                    end else if (cnt_q == '0) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HALT: begin
                    // Absorbing until reset.
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;

    // Saturating increments of the branch and redirect counters.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;
        if (br_valid && stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (redirect && stat_taken_q != 32'hFFFF_FFFF) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end
`endif

endmodule
